gywg_beat_sequencer: RTL and testbench
======================================

// Module: gywg_beat_sequencer
// PURPOSE
//  Parametrised successor to the go/wait/gate timing block. Generates machine timing from a digit strobe:
//  digit counter, prepulse window, scan/action beat sequence and Y-plate clear strobes.
//  Adds a run/stop FSM with manual single-instruction stepping (KSP). Sits between the timebase and control/CRT store.
// PARAMETERS
//  DIGITS_PER_WORD  32  digit periods per word time (>=4)
//  PREPULSE_DIGITS  4   trailing digits of each word forming the prepulse/flyback window (1..DIGITS_PER_WORD-1)
//  BEATS            4   word times per instruction; even = scan beat, odd = action beat (even, >=2)
//  DEBOUNCE_CYCLES  16  clk cycles man_step must be stable (GYWG_DEBOUNCE_EN only)
// PORTS
//  clk                  in   1   system clock, all state on rising edge
//  rst_n                in   1   asynchronous active-low reset
//  digit_tick           in   1   1-cycle strobe, one per digit period
//  run                  in   1   run/stop switch level: 1 = auto run
//  halt_req             in   1   stop instruction decoded by control, 1-cycle pulse
//  man_step             in   1   raw single-step (KSP) button, asynchronous
//  digit_cnt            out  DW  current digit, DW = $clog2(DIGITS_PER_WORD)
//  beat                 out  BEATS one-hot current beat
//  hs                   out  1   1 while in a scan beat (even index)
//  ha                   out  1   1 while in an action beat (odd index)
//  pp_wf                out  1   1 while digit_cnt >= DIGITS_PER_WORD-PREPULSE_DIGITS
//  cl_yplate            out  1   1-cycle pulse on the digit_tick entering the prepulse window, every word
//  instr_gate           out  1   1 throughout beat index 1 (instruction fetch word)
//  action_trigger_auto  out  1   1-cycle pulse on entry to any action beat in RUNNING
//  action_trigger_man   out  1   1-cycle pulse on entry to any action beat in STEPPING
//  stopped              out  1   1 in STOPPED
// BEHAVIOUR
//  - Reset: digit_cnt=0, beat=1 (index 0), hs=1, ha=0, pp_wf=0, all pulses 0, stopped=1, FSM=STOPPED.
//  - Outputs registered; they reflect state one cycle after the digit_tick edge causing change.
//  - digit_cnt advances only on digit_tick, wraps DIGITS_PER_WORD-1 -> 0 (word_end) in every FSM state.
//  - Beat advances on word_end only in RUNNING/STEPPING; wraps BEATS-1 -> 0 (instr_end). Frozen at index 0 in STOPPED.
//  - FSM: STOPPED, RUNNING, STOPPING, STEPPING.
//    STOPPED -> RUNNING at next word_end when run=1 (step_pending cleared).
//    STOPPED -> STEPPING at next word_end when run=0 and step_pending=1; step_pending cleared.
//    RUNNING -> STOPPING when run=0 or halt_req=1; STOPPING finishes current instruction, -> STOPPED at instr_end.
//    STEPPING runs exactly BEATS word times, -> STOPPED at instr_end; halt_req ignored here.
//  - If RUNNING exit condition coincides with instr_end, go straight to STOPPED (no extra instruction).
//  - man_step: 2-flop synchronised, rising edge sets step_pending only in STOPPED; ignored otherwise.
//    Edge and halt_req in same cycle while RUNNING: halt wins, step discarded. Multiple edges before
//    word_end yield one step.
//  - Action triggers fire in the cycle the beat register enters an odd index; none in STOPPED.
//  - cl_yplate fires in all FSM states (display refresh continues while stopped).
//  - rst_n low mid-instruction: immediate return to reset values, no trigger emitted.
// CONFIGURATION
//  GYWG_DEBOUNCE_EN defined: synchronised man_step must hold a new level DEBOUNCE_CYCLES consecutive clk
//    cycles before the debounced level updates; step edge taken from debounced level.
//  Undefined: no debounce counter; edge taken directly from synchroniser output.
// TESTING  (DIGITS_PER_WORD=8, PREPULSE_DIGITS=2, BEATS=4, digit_tick every 2nd cycle)
//  - Reset release, run=0 -> stopped=1, beat=4'b0001, digit_cnt cycles 0..7, cl_yplate pulses each word at digit 6,
//    no triggers.
//  - run=1 -> RUNNING at next wrap; beat 0001,0010,0100,1000 every 8 digits; action_trigger_auto at entry to 0010/1000;
//    instr_gate only in 0010.
//  - halt_req pulse in beat 0100 -> beat 1000 completes, stopped=1 at next wrap with beat=0001; one more auto trigger.
//  - Stopped, man_step pulse -> one 4-beat instruction, exactly 2 action_trigger_man pulses, stopped again.
//  - halt_req and man_step rising same cycle while RUNNING -> stops after instruction, no step follows.
//  - GYWG_DEBOUNCE_EN: 10-cycle glitch on man_step -> no step; 20-cycle press -> one step.
//    rst_n pulse mid-beat 0010 -> all outputs to reset values.

Source files
------------

// File: rtl/gywg_beat_sequencer.sv
// Machine timing generator: digit counter, prepulse window, scan/action beats and a
// run/stop/step FSM. Define GYWG_DEBOUNCE_EN to debounce the man_step button.
module gywg_beat_sequencer #(
    parameter int DIGITS_PER_WORD = 32,
    parameter int PREPULSE_DIGITS = 4,
    parameter int BEATS           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int DW = $clog2(DIGITS_PER_WORD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_tick,
    input  logic             run,
    input  logic             halt_req,
    input  logic             man_step,
    output logic [DW-1:0]    digit_cnt,
    output logic [BEATS-1:0] beat,
    output logic             hs,
    output logic             ha,
    output logic             pp_wf,
    output logic             cl_yplate,
    output logic             instr_gate,
    output logic             action_trigger_auto,
    output logic             action_trigger_man,
    output logic             stopped
);

    if (DIGITS_PER_WORD < 4 || PREPULSE_DIGITS < 1 || PREPULSE_DIGITS >= DIGITS_PER_WORD ||
        BEATS < 2 || (BEATS % 2) != 0 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gywg_beat_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {STOPPED, RUNNING, STOPPING, STEPPING} state_t;

    function automatic logic [BEATS-1:0] odd_mask();
        logic [BEATS-1:0] m;
        m = '0;
        for (int i = 1; i < BEATS; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [DW-1:0]    LAST_DIGIT = DW'(DIGITS_PER_WORD - 1);
    localparam logic [DW-1:0]    PP_START   = DW'(DIGITS_PER_WORD - PREPULSE_DIGITS);
    localparam logic [DW-1:0]    PP_ENTRY   = DW'(DIGITS_PER_WORD - PREPULSE_DIGITS - 1);
    localparam logic [BEATS-1:0] ODD_BEATS  = odd_mask();

    state_t           state, state_next;
    logic             word_end, instr_end, advance, leave_stop;
    logic             auto_next, man_next, entering_odd;
    logic             step_pending, step_edge;
    logic             ms_meta, ms_sync;
    logic [BEATS-1:0] beat_next;

    assign word_end     = digit_tick && (digit_cnt == LAST_DIGIT);
    assign instr_end    = word_end && beat[BEATS-1];
    assign advance      = word_end && (state != STOPPED);
    assign beat_next    = advance ? {beat[BEATS-2:0], beat[BEATS-1]} : beat;
    assign entering_odd = advance && |(beat_next & ODD_BEATS);
    assign leave_stop   = (state == STOPPED) && word_end && (run || step_pending);

    assign hs         = |(beat & ~ODD_BEATS);
    assign ha         = |(beat & ODD_BEATS);
    assign pp_wf      = (digit_cnt >= PP_START);
    assign instr_gate = beat[1];
    assign stopped    = (state == STOPPED);

    // man_step synchroniser, shared by both step-edge variants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_meta <= 1'b0;
            ms_sync <= 1'b0;
        end else begin
            ms_meta <= man_step;
            ms_sync <= ms_meta;
        end
    end

`ifdef GYWG_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt;
    logic          db_level, db_flip;

    assign db_flip   = (ms_sync != db_level) && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign step_edge = db_flip && ms_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (ms_sync == db_level) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            db_cnt   <= '0;
            db_level <= ms_sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    logic ms_prev;

    assign step_edge = ms_sync && !ms_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ms_prev <= 1'b0;
        else        ms_prev <= ms_sync;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STOPPED;
        else        state <= state_next;
    end

    // A run/halt exit landing on instr_end skips STOPPING so no extra instruction starts
    always_comb begin
        state_next = state;
        auto_next  = 1'b0;
        man_next   = 1'b0;
        case (state)
            STOPPED: begin
                if (word_end && run)               state_next = RUNNING;
                else if (word_end && step_pending) state_next = STEPPING;
            end
            RUNNING: begin
                auto_next = entering_odd;
                if (!run || halt_req) state_next = instr_end ? STOPPED : STOPPING;
            end
            STOPPING: begin
                auto_next = entering_odd;
                if (instr_end) state_next = STOPPED;
            end
            STEPPING: begin
                man_next = entering_odd;
                if (instr_end) state_next = STOPPED;
            end
            default: state_next = STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_cnt           <= '0;
            beat                <= BEATS'(1);
            step_pending        <= 1'b0;
            cl_yplate           <= 1'b0;
            action_trigger_auto <= 1'b0;
            action_trigger_man  <= 1'b0;
        end else begin
            if (digit_tick) digit_cnt <= word_end ? '0 : digit_cnt + 1'b1;
            beat                <= beat_next;
            cl_yplate           <= digit_tick && (digit_cnt == PP_ENTRY);
            action_trigger_auto <= auto_next;
            action_trigger_man  <= man_next;
            if (leave_stop)                           step_pending <= 1'b0;
            else if ((state == STOPPED) && step_edge) step_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gywg_beat_sequencer.sv
// Randomised and directed bench for gywg_beat_sequencer against an index/counter level
// reference model; honours GYWG_DEBOUNCE_EN when defined.
module tb_gywg_beat_sequencer;
    localparam int DPW = 8;
    localparam int PP  = 2;
    localparam int NB  = 4;
    localparam int DB  = 16;
    localparam int M_STOPPED = 0, M_RUN = 1, M_STOPPING = 2, M_STEP = 3;

    logic clk = 1'b0, rst_n = 1'b0, digit_tick = 1'b0, run = 1'b0, halt_req = 1'b0, man_step = 1'b0;
    logic [2:0] digit_cnt;
    logic [3:0] beat;
    logic hs, ha, pp_wf, cl_yplate, instr_gate, action_trigger_auto, action_trigger_man, stopped;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;
    int cnt_auto = 0, cnt_man = 0, cnt_cl = 0;

    // reference model state
    int m_digit = 0, m_idx = 0, m_mode = M_STOPPED;
    bit m_pend = 0, m_cl = 0, m_ta = 0, m_tm = 0, m_db = 0;
    logic [31:0] m_hist = '0;

    gywg_beat_sequencer #(
        .DIGITS_PER_WORD(DPW), .PREPULSE_DIGITS(PP), .BEATS(NB), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_tick(digit_tick), .run(run), .halt_req(halt_req),
        .man_step(man_step), .digit_cnt(digit_cnt), .beat(beat), .hs(hs), .ha(ha), .pp_wf(pp_wf),
        .cl_yplate(cl_yplate), .instr_gate(instr_gate), .action_trigger_auto(action_trigger_auto),
        .action_trigger_man(action_trigger_man), .stopped(stopped)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 digit_tick = ~digit_tick;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit we, ie, step_req, all_diff;
        int nd, ni;
        we = digit_tick && (m_digit == DPW - 1);
        ie = we && (m_idx == NB - 1);
        nd = digit_tick ? (m_digit + 1) % DPW : m_digit;
        ni = (we && m_mode != M_STOPPED) ? (m_idx + 1) % NB : m_idx;
        m_cl = digit_tick && (nd == DPW - PP);
        m_ta = (m_mode == M_RUN || m_mode == M_STOPPING) && (ni != m_idx) && (ni % 2 == 1);
        m_tm = (m_mode == M_STEP) && (ni != m_idx) && (ni % 2 == 1);
`ifdef GYWG_DEBOUNCE_EN
        all_diff = 1'b1;
        for (int i = 1; i <= DB; i++) if (m_hist[i] == m_db) all_diff = 1'b0;
        step_req = 1'b0;
        if (all_diff) begin
            m_db = ~m_db;
            step_req = m_db;
        end
`else
        all_diff = 1'b0;
        step_req = m_hist[1] && !m_hist[2];
`endif
        case (m_mode)
            M_STOPPED: begin
                if (we && run) begin
                    m_mode = M_RUN; m_pend = 0;
                end else if (we && m_pend) begin
                    m_mode = M_STEP; m_pend = 0;
                end else if (step_req) begin
                    m_pend = 1;
                end
            end
            M_RUN: if (!run || halt_req) m_mode = ie ? M_STOPPED : M_STOPPING;
            default: if (ie) m_mode = M_STOPPED;
        endcase
        m_digit = nd;
        m_idx   = ni;
        m_hist  = {m_hist[30:0], man_step};
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_digit = 0; m_idx = 0; m_mode = M_STOPPED; m_pend = 0;
            m_cl = 0; m_ta = 0; m_tm = 0; m_db = 0; m_hist = '0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("digit_cnt", digit_cnt, m_digit);
            check("beat", beat, 32'(1) << m_idx);
            check("hs", hs, (m_idx % 2) == 0);
            check("ha", ha, (m_idx % 2) == 1);
            check("pp_wf", pp_wf, m_digit >= DPW - PP);
            check("cl_yplate", cl_yplate, m_cl);
            check("instr_gate", instr_gate, m_idx == 1);
            check("trig_auto", action_trigger_auto, m_ta);
            check("trig_man", action_trigger_man, m_tm);
            check("stopped", stopped, m_mode == M_STOPPED);
            if (action_trigger_auto) cnt_auto++;
            if (action_trigger_man)  cnt_man++;
            if (cl_yplate)           cnt_cl++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input logic [3:0] b, input int budget, input string name);
        int k = 0;
        do begin @(negedge clk); k++; end while (beat !== b && k < budget);
        check(name, beat, b);
    endtask

    task automatic wait_stopped(input logic v, input int budget, input string name);
        int k = 0;
        do begin @(negedge clk); k++; end while (stopped !== v && k < budget);
        check(name, stopped, v);
    endtask

    initial begin
        int snap_a, snap_m, snap_c, ms_hold, k;
        cyc();
        chk_en = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        check("rst_digit", digit_cnt, 0);
        check("rst_beat", beat, 4'b0001);
        check("rst_hs", hs, 1);
        check("rst_ha", ha, 0);
        check("rst_pp", pp_wf, 0);
        check("rst_stopped", stopped, 1);
        check("rst_trig", {action_trigger_auto, action_trigger_man, cl_yplate}, 0);
        cyc();
        rst_n = 1'b1;

        // stopped: display timing keeps running, no triggers
        k = 0;
        do begin @(negedge clk); k++; end while (cl_yplate !== 1'b1 && k < 40);
        check("cl_seen", cl_yplate, 1);
        check("cl_digit", digit_cnt, 6);
        check("cl_pp", pp_wf, 1);
        cyc();
        snap_a = cnt_auto; snap_m = cnt_man; snap_c = cnt_cl;
        repeat (32) cyc();
        check("cl_per_word", cnt_cl - snap_c, 2);
        check("idle_trigs", (cnt_auto - snap_a) + (cnt_man - snap_m), 0);
        check("idle_beat", beat, 4'b0001);

        // run, then halt in beat 2
        run = 1'b1;
        wait_beat(4'b0010, 100, "run_reach_b1");
        check("b1_gate", instr_gate, 1);
        check("b1_ha", ha, 1);
        check("b1_trig", action_trigger_auto, 1);
        wait_beat(4'b0100, 40, "run_reach_b2");
        cyc();
        snap_a = cnt_auto;
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        wait_stopped(1'b1, 100, "halt_stops");
        cyc();
        run = 1'b0;
        check("halt_extra_auto", cnt_auto - snap_a, 1);
        check("halt_beat", beat, 4'b0001);

        // single step
        snap_m = cnt_man;
        man_step = 1'b1;
        repeat (20) cyc();
        man_step = 1'b0;
        wait_stopped(1'b0, 60, "step_starts");
        wait_stopped(1'b1, 100, "step_ends");
        cyc();
        check("step_man_trigs", cnt_man - snap_m, 2);

        // halt and step edge together while running
        run = 1'b1;
        wait_beat(4'b0010, 100, "hs_reach_b1");
        cyc();
        run = 1'b0; halt_req = 1'b1; man_step = 1'b1;
        cyc();
        halt_req = 1'b0;
        repeat (19) cyc();
        man_step = 1'b0;
        wait_stopped(1'b1, 100, "hs_stops");
        cyc();
        snap_m = cnt_man;
        repeat (60) cyc();
        check("hs_no_step", cnt_man - snap_m, 0);
        check("hs_still_stopped", stopped, 1);

        // short press then long press
        snap_m = cnt_man;
        man_step = 1'b1;
        repeat (10) cyc();
        man_step = 1'b0;
        repeat (100) cyc();
`ifdef GYWG_DEBOUNCE_EN
        check("glitch_trigs", cnt_man - snap_m, 0);
`else
        check("short_press_trigs", cnt_man - snap_m, 2);
`endif
        check("short_press_stopped", stopped, 1);
        snap_m = cnt_man;
        man_step = 1'b1;
        repeat (20) cyc();
        man_step = 1'b0;
        repeat (120) cyc();
        check("long_press_trigs", cnt_man - snap_m, 2);

        // asynchronous reset in the middle of beat 1
        run = 1'b1;
        wait_beat(4'b0010, 100, "rst_reach_b1");
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_beat", beat, 4'b0001);
        check("mid_rst_digit", digit_cnt, 0);
        check("mid_rst_stopped", stopped, 1);
        check("mid_rst_gate", {instr_gate, ha, action_trigger_auto}, 0);
        run = 1'b0;
        cyc();
        rst_n = 1'b1;

        // randomised operation
        ms_hold = 5;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            halt_req = ($urandom_range(39) == 0);
            if ($urandom_range(199) == 0) run = ~run;
            rst_n = ($urandom_range(1499) != 0);
            if (ms_hold == 0) begin
                man_step = ~man_step;
                ms_hold = $urandom_range(30, 1);
            end else begin
                ms_hold--;
            end
        end
        cyc();
        rst_n = 1'b1; halt_req = 1'b0;
        repeat (10) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
